rf_bank_dispatcher: RTL and testbench

//  Request side of the 4-bank register file. It accepts operand-read requests from 4 operand

---
 rtl/rf_bank_dispatcher_if.sv | 31 +++
 rtl/rf_bank_dispatcher.sv | 201 ++++++++++++++++++++
 tb/tb_rf_bank_dispatcher.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_bank_dispatcher_if.sv
// Request-side bus of the register-file bank dispatcher: operand-read requests from
// the four operand collectors plus the write-back stream.
interface rf_bank_dispatcher_if;
    localparam int unsigned NOC    = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OCID_W = 4;
    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 256;

    logic [NOC-1:0]          req_valid;
    logic [NOC-1:0]          req_ready;
    logic [NOC*REG_W-1:0]    req_reg;
    logic [NOC*OCID_W-1:0]   req_ocid;
    logic [NOC-1:0]          req_same;
    logic                    wb_valid;
    logic [REG_W-1:0]        wb_reg;
    logic [LANES-1:0]        wb_mask;
    logic [DATA_W-1:0]       wb_data;

    modport master (
        output req_valid, req_reg, req_ocid, req_same,
        output wb_valid, wb_reg, wb_mask, wb_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_reg, req_ocid, req_same,
        input  wb_valid, wb_reg, wb_mask, wb_data,
        output req_ready
    );
endinterface

// File: rtl/rf_bank_dispatcher.sv
// Request side of a 4-bank register file: per-bank read FIFOs with round-robin enqueue
// arbitration, write-back priority on issue, and registered read-data-valid per bank.
module rf_bank_dispatcher #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_bank_dispatcher_if.slave  bus,
    output logic [2:0]           RF_Addr_0,
    output logic [2:0]           RF_Addr_1,
    output logic [2:0]           RF_Addr_2,
    output logic [2:0]           RF_Addr_3,
    output logic                 RF_WR_0,
    output logic                 RF_WR_1,
    output logic                 RF_WR_2,
    output logic                 RF_WR_3,
    output logic [7:0]           RF_WR_MASK,
    output logic [255:0]         WriteData_0,
    output logic [255:0]         WriteData_1,
    output logic [255:0]         WriteData_2,
    output logic [255:0]         WriteData_3,
    output logic [3:0]           ocid_out_0,
    output logic [3:0]           ocid_out_1,
    output logic [3:0]           ocid_out_2,
    output logic [3:0]           ocid_out_3,
    output logic                 same_0,
    output logic                 same_1,
    output logic                 same_2,
    output logic                 same_3,
    output logic                 rd_valid_0,
    output logic                 rd_valid_1,
    output logic                 rd_valid_2,
    output logic                 rd_valid_3
);

    localparam int unsigned NB     = 4;
    localparam int unsigned NOC    = 4;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned OCID_W = 4;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q [NB];
    logic [PTR_W-1:0]  wr_ptr_d [NB];
    logic [PTR_W-1:0]  rd_ptr_q [NB];
    logic [PTR_W-1:0]  rd_ptr_d [NB];
    logic [CNT_W-1:0]  cnt_q    [NB];
    logic [CNT_W-1:0]  cnt_d    [NB];
    logic [1:0]        rr_q     [NB];
    logic [1:0]        rr_d     [NB];
    logic [NB-1:0]     rd_valid_q;
    logic [NB-1:0]     rd_valid_d;

    logic [ROW_W-1:0]  row_q  [NB][DEPTH];
    logic [ROW_W-1:0]  row_d  [NB][DEPTH];
    logic [OCID_W-1:0] ocid_q [NB][DEPTH];
    logic [OCID_W-1:0] ocid_d [NB][DEPTH];
    logic              same_q [NB][DEPTH];
    logic              same_d [NB][DEPTH];

    logic [NB-1:0]     full;
    logic [NB-1:0]     found;
    logic [NB-1:0]     push;
    logic [NB-1:0]     pop;
    logic [NB-1:0]     wr_hit;
    logic [1:0]        win  [NB];
    logic [1:0]        cand;
    logic [NOC-1:0]    ready_c;

    logic [ROW_W-1:0]  addr_c [NB];
    logic [OCID_W-1:0] ocid_c [NB];
    logic [NB-1:0]     same_c;
    logic [7:0]        mask_c;

    // Enqueue arbitration: first contender at or after rr_b wins, accepted only if not full.
    always_comb begin : arb_comb
        ready_c = '0;
        found   = '0;
        push    = '0;
        full    = '0;
        cand    = '0;
        for (int b = 0; b < NB; b++) begin
            win[b]  = '0;
            rr_d[b] = rr_q[b];
        end
        for (int b = 0; b < NB; b++) begin
            full[b] = (cnt_q[b] == CNT_W'(DEPTH));
            for (int k = 0; k < NOC; k++) begin
                cand = rr_q[b] + 2'(k);
                if (!found[b] && bus.req_valid[cand] &&
                    (bus.req_reg[5*int'(cand) +: 2] == 2'(b))) begin
                    found[b] = 1'b1;
                    win[b]   = cand;
                end
            end
            push[b] = found[b] && !full[b];
            if (push[b]) begin
                ready_c[win[b]] = 1'b1;
                rr_d[b]         = win[b] + 2'd1;
            end
        end
    end

    // Issue: a write-back to the bank takes the port and holds the FIFO head.
    always_comb begin : issue_comb
        wr_hit = '0;
        pop    = '0;
        same_c = '0;
        for (int b = 0; b < NB; b++) begin
            addr_c[b] = '0;
            ocid_c[b] = '0;
            wr_hit[b] = bus.wb_valid && (bus.wb_reg[1:0] == 2'(b));
            pop[b]    = !wr_hit[b] && (cnt_q[b] != '0);
            if (wr_hit[b]) begin
                addr_c[b] = bus.wb_reg[4:2];
            end else if (pop[b]) begin
                addr_c[b] = row_q[b][rd_ptr_q[b]];
                ocid_c[b] = ocid_q[b][rd_ptr_q[b]];
                same_c[b] = same_q[b][rd_ptr_q[b]];
            end
        end
        mask_c = bus.wb_valid ? bus.wb_mask : '0;
    end

    always_comb begin : fifo_comb
        row_d      = row_q;
        ocid_d     = ocid_q;
        same_d     = same_q;
        rd_valid_d = pop;
        for (int b = 0; b < NB; b++) begin
            wr_ptr_d[b] = wr_ptr_q[b];
            rd_ptr_d[b] = rd_ptr_q[b];
            cnt_d[b]    = cnt_q[b] + CNT_W'(push[b]) - CNT_W'(pop[b]);
            if (push[b]) begin
                row_d[b][wr_ptr_q[b]]  = bus.req_reg[5*int'(win[b]) + 2 +: 3];
                ocid_d[b][wr_ptr_q[b]] = bus.req_ocid[4*int'(win[b]) +: 4];
                same_d[b][wr_ptr_q[b]] = bus.req_same[win[b]];
                wr_ptr_d[b]            = wr_ptr_q[b] + PTR_W'(1);
            end
            if (pop[b]) begin
                rd_ptr_d[b] = rd_ptr_q[b] + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_ff
        if (rst) begin
            rd_valid_q <= '0;
            for (int b = 0; b < NB; b++) begin
                wr_ptr_q[b] <= '0;
                rd_ptr_q[b] <= '0;
                cnt_q[b]    <= '0;
                rr_q[b]     <= '0;
            end
        end else begin
            rd_valid_q <= rd_valid_d;
            for (int b = 0; b < NB; b++) begin
                wr_ptr_q[b] <= wr_ptr_d[b];
                rd_ptr_q[b] <= rd_ptr_d[b];
                cnt_q[b]    <= cnt_d[b];
                rr_q[b]     <= rr_d[b];
            end
        end
    end

    // Entry storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin : mem_ff
        row_q  <= row_d;
        ocid_q <= ocid_d;
        same_q <= same_d;
    end

    assign bus.req_ready = ready_c;
    assign RF_WR_MASK    = mask_c;

    assign RF_Addr_0 = addr_c[0];
    assign RF_Addr_1 = addr_c[1];
    assign RF_Addr_2 = addr_c[2];
    assign RF_Addr_3 = addr_c[3];
    assign RF_WR_0   = wr_hit[0];
    assign RF_WR_1   = wr_hit[1];
    assign RF_WR_2   = wr_hit[2];
    assign RF_WR_3   = wr_hit[3];
    assign WriteData_0 = bus.wb_data;
    assign WriteData_1 = bus.wb_data;
    assign WriteData_2 = bus.wb_data;
    assign WriteData_3 = bus.wb_data;
    assign ocid_out_0 = ocid_c[0];
    assign ocid_out_1 = ocid_c[1];
    assign ocid_out_2 = ocid_c[2];
    assign ocid_out_3 = ocid_c[3];
    assign same_0 = same_c[0];
    assign same_1 = same_c[1];
    assign same_2 = same_c[2];
    assign same_3 = same_c[3];
    assign rd_valid_0 = rd_valid_q[0];
    assign rd_valid_1 = rd_valid_q[1];
    assign rd_valid_2 = rd_valid_q[2];
    assign rd_valid_3 = rd_valid_q[3];

endmodule

// File: tb/tb_rf_bank_dispatcher.sv
// Bench for rf_bank_dispatcher: directed scenario tasks plus a per-bank scoreboard that
// predicts accepts, issue order and rd_valid timing from an independent behavioural model.
module tb_rf_bank_dispatcher;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [2:0] row;
        logic [3:0] ocid;
        logic       same;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_bank_dispatcher_if bus();

    logic [2:0]   rf_addr  [4];
    logic         rf_wr    [4];
    logic [255:0] wdata    [4];
    logic [3:0]   ocid_out [4];
    logic         same_o   [4];
    logic         rdv      [4];
    logic [7:0]   wr_mask;

    rf_bank_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .RF_Addr_0(rf_addr[0]), .RF_Addr_1(rf_addr[1]), .RF_Addr_2(rf_addr[2]), .RF_Addr_3(rf_addr[3]),
        .RF_WR_0(rf_wr[0]), .RF_WR_1(rf_wr[1]), .RF_WR_2(rf_wr[2]), .RF_WR_3(rf_wr[3]),
        .RF_WR_MASK(wr_mask),
        .WriteData_0(wdata[0]), .WriteData_1(wdata[1]), .WriteData_2(wdata[2]), .WriteData_3(wdata[3]),
        .ocid_out_0(ocid_out[0]), .ocid_out_1(ocid_out[1]), .ocid_out_2(ocid_out[2]), .ocid_out_3(ocid_out[3]),
        .same_0(same_o[0]), .same_1(same_o[1]), .same_2(same_o[2]), .same_3(same_o[3]),
        .rd_valid_0(rdv[0]), .rd_valid_1(rdv[1]), .rd_valid_2(rdv[2]), .rd_valid_3(rdv[3])
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard state: expected read queue per bank, model RR pointers, expected rd_valid.
    ent_t       sbq [4][$];
    logic [1:0] rr_m [4];
    logic [3:0] exp_rdv;
    int         occ [4];
    ent_t       e;
    logic       exp_wr, nrdv, hit, fnd;
    logic [1:0] cand, win;
    logic [3:0] exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                sbq[b].delete();
                rr_m[b] = 2'd0;
            end
            exp_rdv = 4'd0;
        end else begin
            for (int b = 0; b < 4; b++) occ[b] = sbq[b].size();
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (rdv[b] !== exp_rdv[b]) begin
                    errors++;
                    $display("FAIL sb_rd_valid bank %0d got %b want %b t=%0t", b, rdv[b], exp_rdv[b], $time);
                end
                hit = bus.wb_valid && (bus.wb_reg[1:0] == 2'(b));
                e = '0;
                exp_wr = 1'b0;
                nrdv = 1'b0;
                if (hit) begin
                    e.row = bus.wb_reg[4:2];
                    exp_wr = 1'b1;
                end else if (occ[b] > 0) begin
                    e = sbq[b].pop_front();
                    nrdv = 1'b1;
                end
                checks++;
                if ({rf_wr[b], rf_addr[b], ocid_out[b], same_o[b]} !== {exp_wr, e.row, e.ocid, e.same}) begin
                    errors++;
                    $display("FAIL sb_issue bank %0d got wr=%b addr=%0d ocid=%0d same=%b want wr=%b addr=%0d ocid=%0d same=%b t=%0t",
                             b, rf_wr[b], rf_addr[b], ocid_out[b], same_o[b], exp_wr, e.row, e.ocid, e.same, $time);
                end
                checks++;
                if (wdata[b] !== bus.wb_data) begin
                    errors++;
                    $display("FAIL sb_wdata bank %0d got %h want %h", b, wdata[b], bus.wb_data);
                end
                exp_rdv[b] = nrdv;
            end
            checks++;
            if (wr_mask !== (bus.wb_valid ? bus.wb_mask : 8'h00)) begin
                errors++;
                $display("FAIL sb_mask got %h want %h", wr_mask, bus.wb_valid ? bus.wb_mask : 8'h00);
            end
            exp_rdy = 4'd0;
            for (int b = 0; b < 4; b++) begin
                fnd = 1'b0;
                win = 2'd0;
                for (int k = 0; k < 4; k++) begin
                    cand = rr_m[b] + 2'(k);
                    if (!fnd && bus.req_valid[cand] && (bus.req_reg[5*int'(cand) +: 2] == 2'(b))) begin
                        fnd = 1'b1;
                        win = cand;
                    end
                end
                if (fnd && occ[b] < int'(DEPTH)) begin
                    exp_rdy[win] = 1'b1;
                    e.row  = bus.req_reg[5*int'(win) + 2 +: 3];
                    e.ocid = bus.req_ocid[4*int'(win) +: 4];
                    e.same = bus.req_same[win];
                    sbq[b].push_back(e);
                    rr_m[b] = win + 2'd1;
                end
            end
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sb_req_ready got %b want %b t=%0t", bus.req_ready, exp_rdy, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_reg   = '0;
        bus.req_ocid  = '0;
        bus.req_same  = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_mask   = '0;
        bus.wb_data   = '0;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [3:0] o, input logic s);
        bus.req_valid[i]      = 1'b1;
        bus.req_reg[5*i +: 5] = r;
        bus.req_ocid[4*i +: 4] = o;
        bus.req_same[i]       = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1010;
        bus.req_reg   = 20'(5'd3) << 5 | 20'(5'd3) << 15;
        at_neg();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rdv[b] !== 1'b0 || rf_wr[b] !== 1'b0 || rf_addr[b] !== 3'd0 || ocid_out[b] !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle bank %0d got rdv=%b wr=%b addr=%0d ocid=%0d want all 0",
                         b, rdv[b], rf_wr[b], rf_addr[b], ocid_out[b]);
            end
        end
        checks++;
        if (bus.req_ready !== 4'b0010 || wr_mask !== 8'h00) begin
            errors++;
            $display("FAIL reset_rr got ready=%b mask=%h want ready=0010 mask=00", bus.req_ready, wr_mask);
        end
        tick();
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_single();
        clear_inputs();
        set_req(1, 5'd6, 4'd3, 1'b0);
        at_neg();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready got %b want 0010", bus.req_ready);
        end
        tick();
        clear_inputs();
        at_neg();
        checks++;
        if (rf_addr[2] !== 3'd1 || rf_wr[2] !== 1'b0 || ocid_out[2] !== 4'd3) begin
            errors++;
            $display("FAIL single_issue got addr=%0d wr=%b ocid=%0d want 1 0 3", rf_addr[2], rf_wr[2], ocid_out[2]);
        end
        tick();
        at_neg();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rdv[b] !== (b == 2)) begin
                errors++;
                $display("FAIL single_rd_valid bank %0d got %b want %b", b, rdv[b], (b == 2));
            end
        end
        tick();
    endtask

    task automatic test_bank0_order();
        clear_inputs();
        for (int k = 0; k < 4; k++) set_req(k, 5'd0, 4'(k), 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            at_neg();
            if (cyc < 4) begin
                checks++;
                if (bus.req_ready !== 4'(1 << cyc)) begin
                    errors++;
                    $display("FAIL order_ready cyc %0d got %b want %b", cyc, bus.req_ready, 4'(1 << cyc));
                end
            end
            if (cyc >= 1) begin
                checks++;
                if (ocid_out[0] !== 4'(cyc - 1) || rf_wr[0] !== 1'b0 || rf_addr[0] !== 3'd0) begin
                    errors++;
                    $display("FAIL order_issue cyc %0d got ocid=%0d wr=%b addr=%0d want ocid=%0d wr=0 addr=0",
                             cyc, ocid_out[0], rf_wr[0], rf_addr[0], cyc - 1);
                end
            end
            tick();
            if (cyc < 4) bus.req_valid[cyc] = 1'b0;
        end
        at_neg();
        checks++;
        if (rdv[0] !== 1'b1) begin
            errors++;
            $display("FAIL order_last_rd_valid got %b want 1", rdv[0]);
        end
        tick();
    endtask

    task automatic test_wb_hold();
        logic [255:0] d;
        d = {8{$urandom}};
        clear_inputs();
        set_req(0, 5'd1, 4'd5, 1'b0);
        at_neg();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wbhold_ready got %b want 0001", bus.req_ready);
        end
        tick();
        clear_inputs();
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd1;
        bus.wb_mask  = 8'hF0;
        bus.wb_data  = d;
        at_neg();
        checks++;
        if (rf_wr[1] !== 1'b1 || rf_addr[1] !== 3'd0 || wr_mask !== 8'hF0 || ocid_out[1] !== 4'd0 || wdata[1] !== d) begin
            errors++;
            $display("FAIL wbhold_write got wr=%b addr=%0d mask=%h ocid=%0d want 1 0 F0 0", rf_wr[1], rf_addr[1], wr_mask, ocid_out[1]);
        end
        tick();
        clear_inputs();
        at_neg();
        checks++;
        if (rf_wr[1] !== 1'b0 || ocid_out[1] !== 4'd5 || rdv[1] !== 1'b0 || wr_mask !== 8'h00) begin
            errors++;
            $display("FAIL wbhold_read got wr=%b ocid=%0d rdv=%b mask=%h want 0 5 0 00", rf_wr[1], ocid_out[1], rdv[1], wr_mask);
        end
        tick();
        at_neg();
        checks++;
        if (rdv[1] !== 1'b1) begin
            errors++;
            $display("FAIL wbhold_rd_valid got %b want 1", rdv[1]);
        end
        tick();
    endtask

    task automatic test_wb_starve();
        clear_inputs();
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.wb_valid = 1'b1;
            bus.wb_reg   = 5'd3;
            bus.wb_mask  = 8'hFF;
            bus.wb_data  = {8{$urandom}};
            set_req(2, {3'(cyc), 2'd3}, 4'(cyc + 8), 1'b0);
            set_req(0, {3'(cyc), 2'd0}, 4'(cyc), 1'b0);
            at_neg();
            checks++;
            if (bus.req_ready[2] !== (cyc < 4) || bus.req_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL starve_ready cyc %0d got %b want oc2=%b oc0=1", cyc, bus.req_ready, (cyc < 4));
            end
            tick();
        end
        clear_inputs();
        repeat (8) tick();
    endtask

    task automatic test_reset_flush();
        clear_inputs();
        for (int cyc = 0; cyc < 3; cyc++) begin
            bus.wb_valid = 1'b1;
            bus.wb_reg   = 5'd2;
            bus.wb_mask  = 8'h0F;
            set_req(0, 5'd2, 4'(cyc + 1), 1'b0);
            if (cyc == 2) set_req(1, 5'd1, 4'd9, 1'b0);
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 5'd2, 4'(10 + k), 1'b0);
        at_neg();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rdv[b] !== 1'b0 || rf_wr[b] !== 1'b0 || rf_addr[b] !== 3'd0 || ocid_out[b] !== 4'd0) begin
                errors++;
                $display("FAIL flush_idle bank %0d got rdv=%b wr=%b addr=%0d ocid=%0d want all 0",
                         b, rdv[b], rf_wr[b], rf_addr[b], ocid_out[b]);
            end
        end
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL flush_rr got %b want 0001", bus.req_ready);
        end
        tick();
        clear_inputs();
        at_neg();
        checks++;
        if (ocid_out[2] !== 4'd10 || rf_addr[2] !== 3'd0) begin
            errors++;
            $display("FAIL flush_first_issue got ocid=%0d addr=%0d want 10 0", ocid_out[2], rf_addr[2]);
        end
        repeat (3) tick();
    endtask

    task automatic test_same_all_banks();
        logic [2:0] er [4];
        logic [3:0] eo [4];
        er = '{3'd1, 3'd2, 3'd3, 3'd7};
        eo = '{4'd2, 4'd7, 4'd11, 4'd15};
        clear_inputs();
        set_req(0, 5'd9,  4'd7,  1'b1);
        set_req(1, 5'd4,  4'd2,  1'b0);
        set_req(2, 5'd14, 4'd11, 1'b0);
        set_req(3, 5'd31, 4'd15, 1'b0);
        at_neg();
        checks++;
        if (bus.req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL all_ready got %b want 1111", bus.req_ready);
        end
        tick();
        clear_inputs();
        at_neg();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rf_addr[b] !== er[b] || ocid_out[b] !== eo[b] || same_o[b] !== (b == 1) || rf_wr[b] !== 1'b0) begin
                errors++;
                $display("FAIL all_issue bank %0d got addr=%0d ocid=%0d same=%b wr=%b want %0d %0d %b 0",
                         b, rf_addr[b], ocid_out[b], same_o[b], rf_wr[b], er[b], eo[b], (b == 1));
            end
        end
        tick();
        at_neg();
        checks++;
        if ({rdv[3], rdv[2], rdv[1], rdv[0]} !== 4'b1111) begin
            errors++;
            $display("FAIL all_rd_valid got %b%b%b%b want 1111", rdv[3], rdv[2], rdv[1], rdv[0]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            clear_inputs();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) != 0) set_req(i, 5'($urandom), 4'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.wb_valid = 1'b1;
                bus.wb_reg   = 5'($urandom);
                bus.wb_mask  = 8'($urandom);
                bus.wb_data  = {8{$urandom}};
            end
            tick();
        end
        clear_inputs();
        repeat (12) tick();
        at_neg();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (sbq[b].size() != 0) begin
                errors++;
                $display("FAIL drain bank %0d outstanding %0d want 0", b, sbq[b].size());
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_bank0_order();
        test_wb_hold();
        test_wb_starve();
        test_reset_flush();
        test_same_all_banks();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
